ninjakun_cpu_bus_share: RTL

- Generates the two interleaved Z80 clocks (CP0CL, CP1CL) from the 24 MHz shared clock.
- Time-slots both CPUs onto the single I/O/video bus (CPADR/CPODT/CPRED/CPWRT) served by the I/O-video block.
- Returns bus read data to each CPU through a per-CPU latch.
- Sits between the two Z80 cores and the I/O-video block, in the main CPU section.

---
 rtl/ninjakun_cpu_bus_share_pkg.sv | 25 ++
 rtl/ninjakun_cpu_bus_share_if.sv | 15 +
 rtl/ninjakun_bus_port.sv | 104 ++++++++++
 rtl/ninjakun_cpu_bus_share.sv | 92 +++++++++
 4 files changed

// File: rtl/ninjakun_cpu_bus_share_pkg.sv
// Shared constants for the dual-Z80 bus sharer: the phase layout of the
// 8-cycle frame and the idle read-data value.
package ninjakun_cpu_bus_share_pkg;

  localparam int PH_W = 3;
  typedef logic [PH_W-1:0] phase_t;

  // CPU0 owns phases 0..3, CPU1 owns phases 4..7.
  localparam phase_t SLOT0_START = 3'd0;
  localparam phase_t SLOT1_START = 3'd4;
  // Single-cycle write strobe position inside each slot.
  localparam phase_t WR_PH0      = 3'd2;
  localparam phase_t WR_PH1      = 3'd6;
  // Last phase of each slot; read data is captured at its end.
  localparam phase_t RD_LATCH0   = 3'd3;
  localparam phase_t RD_LATCH1   = 3'd7;

  localparam logic [7:0] RD_IDLE_DEF = 8'hFF;

  // CPU0 clock is high during its own slot, low during CPU1's.
  function automatic logic clk0_level(input phase_t p);
    return (p < SLOT1_START);
  endfunction

endpackage

// File: rtl/ninjakun_cpu_bus_share_if.sv
// Shared I/O-video bus: the sharer drives address/data/strobes (master),
// the I/O-video block returns read data combinationally (slave).
interface ninjakun_cpu_bus_share_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] CPADR;
  logic [DATA_W-1:0] CPODT;
  logic [DATA_W-1:0] CPIDT;
  logic              CPRED;
  logic              CPWRT;

  modport master (output CPADR, CPODT, CPRED, CPWRT, input CPIDT);
  modport slave  (input CPADR, CPODT, CPRED, CPWRT, output CPIDT);
endinterface

// File: rtl/ninjakun_bus_port.sv
// Per-CPU bus port: samples the CPU request at slot start, generates this
// CPU's read/write strobes, suppresses repeated writes of a held Z80 write
// cycle, and latches read data at the end of the slot.
module ninjakun_bus_port
  import ninjakun_cpu_bus_share_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] RD_IDLE    = DATA_W'(RD_IDLE_DEF),
  parameter phase_t            SLOT_START = SLOT0_START,
  parameter phase_t            WR_PH      = WR_PH0,
  parameter phase_t            RD_LATCH   = RD_LATCH0
) (
  input  logic              clk,
  input  logic              rst,
  input  phase_t            p_q,
  input  phase_t            p_d,
  // The slot in progress when reset releases has no entry edge, so it is
  // sampled on its first edge instead.
  input  logic              fresh,
  input  logic [ADDR_W-1:0] cpu_ad,
  input  logic [DATA_W-1:0] cpu_od,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] bus_idt,
  output logic [ADDR_W-1:0] ad_q,
  output logic [DATA_W-1:0] od_q,
  output logic              rd_stb_q,
  output logic              wr_stb_q,
  output logic [DATA_W-1:0] id_q
);

  logic [ADDR_W-1:0] ad_d, last_ad_q, last_ad_d;
  logic [DATA_W-1:0] od_d, id_d;
  logic              rd_act_q, rd_act_d;
  logic              wr_act_q, wr_act_d;
  logic              wr_done_q, wr_done_d;
  logic              rd_stb_d, wr_stb_d;
  logic              sample;
  logic              done_keep;

  // Next-state: slot-start sampling, strobe shaping, write dedup, read latch.
  always_comb begin
    ad_d      = ad_q;
    od_d      = od_q;
    rd_act_d  = rd_act_q;
    wr_act_d  = wr_act_q;
    wr_done_d = wr_done_q;
    last_ad_d = last_ad_q;
    id_d      = id_q;
    done_keep = 1'b0;
    sample    = (p_d == SLOT_START) || fresh;

    if (sample) begin
      ad_d      = cpu_ad;
      od_d      = cpu_od;
      // A write already issued stays "done" only while the CPU keeps the
      // same write cycle going (WR high, same address).
      done_keep = wr_done_q && cpu_wr && (cpu_ad == last_ad_q);
      wr_done_d = done_keep;
      wr_act_d  = cpu_wr && !done_keep;
      // Write has priority over a simultaneous read request.
      rd_act_d  = cpu_rd && !cpu_wr;
    end

    rd_stb_d = rd_act_d && (p_d > SLOT_START) && (p_d <= RD_LATCH);
    wr_stb_d = wr_act_d && (p_d == WR_PH);

    if (wr_stb_d) begin
      wr_done_d = 1'b1;
      last_ad_d = ad_d;
    end

    if (rd_act_q && (p_q == RD_LATCH)) begin
      id_d = bus_idt;
    end
  end

  // State and strobe registers; reset clears strobes at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_q      <= '0;
      od_q      <= '0;
      rd_act_q  <= 1'b0;
      wr_act_q  <= 1'b0;
      wr_done_q <= 1'b0;
      last_ad_q <= '0;
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      id_q      <= RD_IDLE;
    end else begin
      ad_q      <= ad_d;
      od_q      <= od_d;
      rd_act_q  <= rd_act_d;
      wr_act_q  <= wr_act_d;
      wr_done_q <= wr_done_d;
      last_ad_q <= last_ad_d;
      rd_stb_q  <= rd_stb_d;
      wr_stb_q  <= wr_stb_d;
      id_q      <= id_d;
    end
  end

endmodule

// File: rtl/ninjakun_cpu_bus_share.sv
// Dual-Z80 bus sharer: runs the 8-phase frame on SHCLK, generates the two
// interleaved 3 MHz CPU clocks and time-slots both CPUs onto the shared
// I/O-video bus.
module ninjakun_cpu_bus_share
  import ninjakun_cpu_bus_share_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] RD_IDLE = DATA_W'(RD_IDLE_DEF)
) (
  input  logic                        SHCLK,
  input  logic                        RESET,
  ninjakun_cpu_bus_share_if.master    bus,
  output logic                        CP0CL,
  input  logic [ADDR_W-1:0]           CP0AD,
  input  logic [DATA_W-1:0]           CP0OD,
  output logic [DATA_W-1:0]           CP0ID,
  input  logic                        CP0RD,
  input  logic                        CP0WR,
  output logic                        CP1CL,
  input  logic [ADDR_W-1:0]           CP1AD,
  input  logic [DATA_W-1:0]           CP1OD,
  output logic [DATA_W-1:0]           CP1ID,
  input  logic                        CP1RD,
  input  logic                        CP1WR
);

  phase_t p_q, p_d;
  logic   fresh_q, fresh_d;
  logic   cp0cl_q, cp0cl_d;
  logic   cp1cl_q, cp1cl_d;

  logic [ADDR_W-1:0] ad0, ad1;
  logic [DATA_W-1:0] od0, od1;
  logic              rd0, rd1, wr0, wr1;

  // Next phase and clock levels; clocks track the phase they will show.
  always_comb begin
    p_d     = p_q + 1'b1;
    fresh_d = 1'b0;
    cp0cl_d = clk0_level(p_d);
    cp1cl_d = !cp0cl_d;
  end

  // Phase counter, first-slot marker and CPU clock flops.
  always_ff @(posedge SHCLK or posedge RESET) begin
    if (RESET) begin
      p_q     <= SLOT0_START;
      fresh_q <= 1'b1;
      cp0cl_q <= 1'b0;
      cp1cl_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      fresh_q <= fresh_d;
      cp0cl_q <= cp0cl_d;
      cp1cl_q <= cp1cl_d;
    end
  end

  ninjakun_bus_port #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_IDLE(RD_IDLE),
    .SLOT_START(SLOT0_START), .WR_PH(WR_PH0), .RD_LATCH(RD_LATCH0)
  ) u_port0 (
    .clk(SHCLK), .rst(RESET), .p_q(p_q), .p_d(p_d), .fresh(fresh_q),
    .cpu_ad(CP0AD), .cpu_od(CP0OD), .cpu_rd(CP0RD), .cpu_wr(CP0WR),
    .bus_idt(bus.CPIDT),
    .ad_q(ad0), .od_q(od0), .rd_stb_q(rd0), .wr_stb_q(wr0), .id_q(CP0ID)
  );

  ninjakun_bus_port #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_IDLE(RD_IDLE),
    .SLOT_START(SLOT1_START), .WR_PH(WR_PH1), .RD_LATCH(RD_LATCH1)
  ) u_port1 (
    .clk(SHCLK), .rst(RESET), .p_q(p_q), .p_d(p_d), .fresh(1'b0),
    .cpu_ad(CP1AD), .cpu_od(CP1OD), .cpu_rd(CP1RD), .cpu_wr(CP1WR),
    .bus_idt(bus.CPIDT),
    .ad_q(ad1), .od_q(od1), .rd_stb_q(rd1), .wr_stb_q(wr1), .id_q(CP1ID)
  );

  // Output mux: the slot owner's held address/data; each port's strobes
  // are zero outside its own slot, so they can simply be ORed.
  always_comb begin
    bus.CPADR = (p_q >= SLOT1_START) ? ad1 : ad0;
    bus.CPODT = (p_q >= SLOT1_START) ? od1 : od0;
    bus.CPRED = rd0 | rd1;
    bus.CPWRT = wr0 | wr1;
  end

  assign CP0CL = cp0cl_q;
  assign CP1CL = cp1cl_q;

endmodule
